// File: rtl/sm2201_isa_cycle_ctrl.sv
// sm2201_isa_cycle_ctrl
// ISA I/O cycle controller for the SM2201 ISA-CAMAC board. Decodes host
// IOR#/IOW# at a fixed base address, drives the 8216/8226 transceiver
// chip-select and direction, holds the host with IOCHRDY and issues timed
// register strobes towards the CAMAC-side logic. All outputs are registered.

module sm2201_isa_cycle_ctrl #(
    parameter logic [9:0] BASE_ADDR     = 10'h300,
    parameter int         ADDR_BITS     = 3,
    parameter int         SETUP_CYCLES  = 2,
    parameter int         STROBE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           isa_addr,
    input  logic                 isa_aen,
    input  logic                 isa_ior_n,
    input  logic                 isa_iow_n,
    output logic                 isa_iochrdy,
    output logic                 xcvr_cs_n,
    output logic                 xcvr_dce,
    output logic [ADDR_BITS-1:0] reg_addr,
    output logic                 wr_stb,
    output logic                 rd_stb,
    output logic                 busy,
    output logic                 err_pulse,
    output logic                 abort_pulse
);

    localparam int CNT_MAX = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         ior_sync, iow_sync;
    logic               err_lock, lock_d;
    logic               iochrdy_d, cs_n_d, dce_d, wr_d, rd_d, busy_d, err_d, abort_d;
    logic [ADDR_BITS-1:0] reg_addr_d;

    // Bit 1 is the synchronised level, bit 2 is the one-clock-delayed copy
    // used to spot a falling edge.
    logic ior_s, iow_s, ior_fall, iow_fall, addr_match, active_high;

    assign ior_s      = ior_sync[1];
    assign iow_s      = iow_sync[1];
    assign ior_fall   = !ior_sync[1] && ior_sync[2];
    assign iow_fall   = !iow_sync[1] && iow_sync[2];
    assign addr_match = (isa_addr[9:ADDR_BITS] == BASE_ADDR[9:ADDR_BITS]);

    // Two-flop synchronisers plus an edge-detect delay flop; idle level is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ior_sync <= 3'b111;
            iow_sync <= 3'b111;
        end else begin
            ior_sync <= {ior_sync[1:0], isa_ior_n};
            iow_sync <= {iow_sync[1:0], isa_iow_n};
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            err_lock    <= 1'b0;
            isa_iochrdy <= 1'b1;
            xcvr_cs_n   <= 1'b1;
            xcvr_dce    <= 1'b0;
            reg_addr    <= '0;
            wr_stb      <= 1'b0;
            rd_stb      <= 1'b0;
            busy        <= 1'b0;
            err_pulse   <= 1'b0;
            abort_pulse <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_lock    <= lock_d;
            isa_iochrdy <= iochrdy_d;
            xcvr_cs_n   <= cs_n_d;
            xcvr_dce    <= dce_d;
            reg_addr    <= reg_addr_d;
            wr_stb      <= wr_d;
            rd_stb      <= rd_d;
            busy        <= busy_d;
            err_pulse   <= err_d;
            abort_pulse <= abort_d;
        end
    end

    // Next-state and next-output logic; the direction register doubles as
    // the record of which host strobe owns the current cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lock_d      = err_lock;
        iochrdy_d   = isa_iochrdy;
        cs_n_d      = xcvr_cs_n;
        dce_d       = xcvr_dce;
        reg_addr_d  = reg_addr;
        wr_d        = wr_stb;
        rd_d        = rd_stb;
        busy_d      = busy;
        err_d       = 1'b0;
        abort_d     = 1'b0;
        active_high = xcvr_dce ? iow_s : ior_s;

        unique case (state_q)
            IDLE: begin
                if (err_lock) begin
                    if (ior_s && iow_s) begin
                        lock_d = 1'b0;
                    end
                end else if ((ior_fall || iow_fall) && !isa_aen && addr_match) begin
                    if (!ior_s && !iow_s) begin
                        err_d  = 1'b1;
                        lock_d = 1'b1;
                    end else begin
                        state_d    = SETUP;
                        cnt_d      = '0;
                        dce_d      = !iow_s;
                        reg_addr_d = isa_addr[ADDR_BITS-1:0];
                        iochrdy_d  = 1'b0;
                        busy_d     = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (active_high) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    cs_n_d    = 1'b1;
                    iochrdy_d = 1'b1;
                    wr_d      = 1'b0;
                    rd_d      = 1'b0;
                    busy_d    = 1'b0;
                    abort_d   = 1'b1;
                end else begin
                    cs_n_d = 1'b0;
                    if (cnt_q == SETUP_LAST) begin
                        state_d = STROBE;
                        cnt_d   = '0;
                        wr_d    = xcvr_dce;
                        rd_d    = !xcvr_dce;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            STROBE: begin
                if (active_high) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    cs_n_d    = 1'b1;
                    iochrdy_d = 1'b1;
                    wr_d      = 1'b0;
                    rd_d      = 1'b0;
                    busy_d    = 1'b0;
                    abort_d   = 1'b1;
                end else if (cnt_q == STROBE_LAST) begin
                    state_d   = HOLD;
                    cnt_d     = '0;
                    wr_d      = 1'b0;
                    rd_d      = 1'b0;
                    iochrdy_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (active_high) begin
                    state_d = IDLE;
                    cs_n_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/sm2201_isa_cycle_ctrl.md
# sm2201_isa_cycle_ctrl

ISA I/O cycle controller for the SM2201 ISA-CAMAC interface board, directly upstream of the 8216/8226 bus transceiver pair. It decodes host I/O read/write strobes at a fixed base address and drives the transceiver chip-select `xcvr_cs_n` and direction `xcvr_dce`. It also inserts ISA wait states via `isa_iochrdy` and issues timed register read/write strobes to the CAMAC-side logic. All host inputs are asynchronous and are synchronised internally.

## Interface
- `BASE_ADDR`, 10'h300: I/O base address; bits [9:ADDR_BITS] are compared.
- `ADDR_BITS`, 3: width of the register index (`reg_addr`); the window is 2^ADDR_BITS ports.
- `SETUP_CYCLES`, 2: clocks from cycle start to strobe assertion; minimum 2.
- `STROBE_CYCLES`, 4: width of `rd_stb`/`wr_stb` in clocks; minimum 1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `isa_addr`  in  10  ISA SA[9:0].
- `isa_aen`  in  1  ISA AEN; 1 means a DMA cycle, and no decode takes place.
- `isa_ior_n`  in  1  ISA IOR#, asynchronous.
- `isa_iow_n`  in  1  ISA IOW#, asynchronous.
- `isa_iochrdy`  out  1  0 = wait state requested, 1 = ready.
- `xcvr_cs_n`  out  1  transceiver chip select, active low.
- `xcvr_dce`  out  1  transceiver direction: 1 = ISA bus → local (write), 0 = local → ISA bus (read).
- `reg_addr`  out  ADDR_BITS  latched register index.
- `wr_stb`  out  1  local write strobe; data on the transceiver `d_out` side is valid.
- `rd_stb`  out  1  local read strobe; local logic drives the transceiver `d_in` side.
- `busy`  out  1  high in any state other than IDLE.
- `err_pulse`  out  1  one-clock pulse when IOR# and IOW# are both low at detection.
- `abort_pulse`  out  1  one-clock pulse when the host releases the strobe before HOLD.

## Operation
- **Synchroniser:** `isa_ior_n` and `isa_iow_n` each pass through a 2-FF synchroniser plus a third delay FF used for edge detection. A falling edge is detected when the synchronised value is 0 and the delayed value is 1.
- **Reset values:** state IDLE, counters 0, `isa_iochrdy`=1, `xcvr_cs_n`=1, `xcvr_dce`=0, `reg_addr`=0, `wr_stb`=`rd_stb`=`busy`=`err_pulse`=`abort_pulse`=0. All synchroniser FFs reset to 1.
- **Decode:** a cycle starts only in IDLE, on a detected falling edge, when `isa_aen`=0 and `isa_addr[9:ADDR_BITS]`==`BASE_ADDR[9:ADDR_BITS]`. Address and AEN are sampled on the edge that leaves IDLE. Non-matching cycles are ignored and no output changes.
- **FSM states:** IDLE → SETUP → STROBE → HOLD → IDLE.
- **IDLE → SETUP edge:**
  - `xcvr_dce` is loaded (1 for IOW#, 0 for IOR#).
  - `reg_addr` is loaded from `isa_addr[ADDR_BITS-1:0]`.
  - `isa_iochrdy` goes to 0 and `busy` goes to 1.
- **SETUP:** `xcvr_cs_n` goes to 0 on the first edge after SETUP is entered, so `xcvr_dce` is stable for at least one clock before CS# falls. SETUP lasts exactly SETUP_CYCLES clocks.
- **STROBE:** the matching strobe (`wr_stb` for a write, `rd_stb` for a read) is high for exactly STROBE_CYCLES clocks.
- **HOLD:**
  - On entry: strobe goes to 0 and `isa_iochrdy` goes to 1.
  - `xcvr_cs_n` stays 0 until the synchronised active strobe returns high.
  - On the edge that sees it high, the FSM returns to IDLE, `xcvr_cs_n` goes to 1 and `busy` goes to 0.
- **Direction stability:** `xcvr_dce` changes only on the IDLE → SETUP edge. It holds its last value in IDLE and never changes while `xcvr_cs_n`=0.
- **Simultaneous IOR#/IOW#:** if both synchronised strobes are low at detection, no cycle starts, `err_pulse`=1 for one clock, and the FSM stays IDLE until both are high again.
- **Abort:** if the active synchronised strobe returns high in SETUP or STROBE, the next edge does all of the following:
  - goes to IDLE;
  - sets `xcvr_cs_n`=1, `isa_iochrdy`=1 and `rd_stb`=`wr_stb`=0;
  - pulses `abort_pulse` for one clock.
- **Inactive strobe:** falling edges on the inactive strobe during a cycle are ignored.
- **Reset mid-cycle:** asynchronously forces the reset values immediately. Any strobe in progress is truncated and `isa_iochrdy` releases to 1.

## Timing
- Strobe fall to the SETUP edge: 3rd rising `clk` edge after IOR#/IOW# falls (input meeting FF setup).
- SETUP entry to `xcvr_cs_n` low: 1 clock.
- SETUP entry to strobe high: SETUP_CYCLES clocks.
- Strobe high to `isa_iochrdy` high: STROBE_CYCLES clocks.
- Total wait-state window: SETUP_CYCLES + STROBE_CYCLES clocks.
- Host strobe rise to `xcvr_cs_n` high: 3 clocks (synchroniser + 1).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Write:** default parameters; IOW# low, `isa_addr`=0x305, AEN=0. Required: `xcvr_dce`=1 and `reg_addr`=5 at edge 3, `xcvr_cs_n`=0 at edge 4, `wr_stb`=1 on edges 5–8, `isa_iochrdy`=0 on edges 3–8 and 1 at edge 9. After IOW# rises, `xcvr_cs_n`=1 three clocks later.
- **Read:** IOR# low at 0x302. Required: `xcvr_dce`=0, `reg_addr`=2, `rd_stb` high for 4 clocks, `wr_stb` stays 0.
- **Decode rejection:** IOW# at 0x308, and separately IOW# at 0x305 with AEN=1. Required: all outputs remain at reset values.
- **Both strobes low:** IOR# and IOW# low together. Required: `err_pulse` for one clock, no `xcvr_cs_n` activity, a normal cycle is accepted after both rise.
- **Abort:** IOR# released 1 clock after `rd_stb` rises. Required: `abort_pulse`, `rd_stb`=0, `xcvr_cs_n`=1, `isa_iochrdy`=1 on the same edge.
- **Reset mid-strobe:** `rst` asserted while `wr_stb`=1. Required: all outputs immediately at reset values, including `isa_iochrdy`=1.
